// File: rtl/plu_mac_seq.sv
// Sequential weighted-sum unit: one shared MAC, start/done handshake, Q-format saturated output.
// Optional PLU_RELU_EN: applies max(0,x) to the saturated result before it is loaded into out.
module plu_mac_seq #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_IN*WIDTH-1:0]   w_flat,
    input  logic [N_IN*WIDTH-1:0]   a_flat,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        out
);
    localparam int IW = $clog2(N_IN);
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + IW;
    localparam logic [IW-1:0] LAST = IW'(N_IN - 1);
    localparam logic signed [AW-1:0] MAXV = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                         state, state_nxt;
    logic [N_IN-1:0][WIDTH-1:0]     w_q, a_q;
    logic [IW-1:0]                  idx;
    logic signed [AW-1:0]           acc;
    logic signed [PW-1:0]           w_ext, a_ext, prod;
    logic signed [AW-1:0]           shifted;
    logic [WIDTH-1:0]               res;
    logic                           accept, mac_en, out_ld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (idx == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && start;
        mac_en = (state == MAC);
        out_ld = (state == DONE);
    end

    // Operands are sign-extended first so the product is exact at full 2*WIDTH precision.
    always_comb begin
        w_ext = PW'($signed(w_q[idx]));
        a_ext = PW'($signed(a_q[idx]));
        prod  = w_ext * a_ext;
    end

    // DONE is a one-cycle formatting stage: shift, clamp, then optional rectification.
    always_comb begin
        shifted = acc >>> FRAC;
        if (shifted > MAXV)      res = MAXV[WIDTH-1:0];
        else if (shifted < MINV) res = MINV[WIDTH-1:0];
        else                     res = shifted[WIDTH-1:0];
`ifdef PLU_RELU_EN
        if (res[WIDTH-1]) res = '0;
`else
        res = res;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q  <= '0;
            a_q  <= '0;
            acc  <= '0;
            idx  <= '0;
            out  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                w_q <= w_flat;
                a_q <= a_flat;
                acc <= '0;
                idx <= '0;
            end
            if (mac_en) begin
                acc <= acc + AW'(prod);
                idx <= idx + IW'(1);
            end
            if (out_ld) begin
                out  <= res;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_plu_mac_seq.sv
// Randomized bench for plu_mac_seq against an integer-arithmetic reference of the weighted sum.
module tb_plu_mac_seq;
    localparam int N = 4;
    localparam int W = 16;
    localparam int F = 8;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [VW-1:0] w_flat = '0;
    logic [VW-1:0] a_flat = '0;
    logic          busy, done;
    logic [W-1:0]  out;

    int total = 0;
    int bad   = 0;

    plu_mac_seq #(.N_IN(N), .WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .rst(rst), .start(start), .w_flat(w_flat), .a_flat(a_flat),
        .busy(busy), .done(done), .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] pack4(input logic [W-1:0] e0, e1, e2, e3);
        logic [VW-1:0] v;
        v = {e3, e2, e1, e0};
        return v;
    endfunction

    // mode 0: full range, 1: small magnitudes, 2: extremes only
    function automatic logic [VW-1:0] rand_vec(input int mode);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) begin
            case (mode)
                1:       v[i*W +: W] = W'($signed($urandom_range(0, 1023)) - 512);
                2:       v[i*W +: W] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
                default: v[i*W +: W] = W'($urandom);
            endcase
        end
        return v;
    endfunction

    // Reference: exact integer dot product, floor-divide by 2^F, clamp, optional ReLU.
    function automatic logic [W-1:0] model(input logic [VW-1:0] w, input logic [VW-1:0] a);
        longint s, mx, mn;
        logic [W-1:0] wi, ai;
        s  = 0;
        mx = (longint'(1) <<< (W - 1)) - 1;
        mn = -(longint'(1) <<< (W - 1));
        for (int i = 0; i < N; i++) begin
            wi = w[i*W +: W];
            ai = a[i*W +: W];
            s += longint'($signed(wi)) * longint'($signed(ai));
        end
        s = s >>> F;
        if (s > mx) s = mx;
        if (s < mn) s = mn;
`ifdef PLU_RELU_EN
        if (s < 0) s = 0;
`endif
        return W'(s);
    endfunction

    // Single start pulse; checks busy, done timing (exactly after edge k+N+1), result and hold.
    task automatic do_op(input string tag, input logic [VW-1:0] w, input logic [VW-1:0] a);
        logic [W-1:0] exp;
        int ndone;
        exp = model(w, a);
        start = 1'b1; w_flat = w; a_flat = a;
        tick();
        start = 1'b0; w_flat = rand_vec(0); a_flat = rand_vec(0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        ndone = 0;
        for (int i = 0; i < N; i++) begin
            tick();
            if (done) ndone++;
        end
        chk({tag, "_early_done"}, 32'(ndone), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_out"}, 32'(out), 32'(exp));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(out), 32'(exp));
    endtask

    initial begin
        logic [VW-1:0] w1, a1;
        logic [W-1:0]  e1;
        logic [W-1:0]  expq[$];
        int            ndone;

        #3;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        do_op("basic", pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100),
                       pack4(16'h0100, 16'h0200, 16'h0300, 16'h0400));
        chk("basic_const", 32'(out), 32'h0A00);

        do_op("inhib_pos", pack4(16'h0100, 16'hFFE6, 16'hFFE6, 16'hFFE6),
                           pack4(16'h0200, 16'h0200, 16'h0200, 16'h0200));
        do_op("inhib_neg", pack4(16'h0100, 16'hFFE6, 16'hFFE6, 16'hFFE6),
                           pack4(16'h0040, 16'h0200, 16'h0200, 16'h0200));
        do_op("sat_max", {N{16'h7FFF}}, {N{16'h7FFF}});
        do_op("sat_min", {N{16'h8000}}, {N{16'h7FFF}});

        for (int t = 0; t < 24; t++)
            do_op($sformatf("rnd%0d", t), rand_vec(t % 3), rand_vec((t / 3) % 3));

        // Second start at edge k+2 must be ignored.
        w1 = rand_vec(1); a1 = rand_vec(1); e1 = model(w1, a1);
        start = 1'b1; w_flat = w1; a_flat = a1;
        tick();
        start = 1'b0; w_flat = rand_vec(0); a_flat = rand_vec(0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 3 * N; i++) begin
            if (done) begin
                ndone++;
                chk("busy_ign_out", 32'(out), 32'(e1));
            end
            tick();
        end
        chk("busy_ign_cnt", 32'(ndone), 32'd1);
        do_op("after_ign", rand_vec(0), rand_vec(0));

        // Reset in the middle of a computation.
        start = 1'b1; w_flat = rand_vec(1); a_flat = rand_vec(1);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_out", 32'(out), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done) ndone++;
        end
        rst = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            if (done) ndone++;
            if (i < 1) tick();
        end
        chk("mrst_no_done", 32'(ndone), 32'd0);
        do_op("post_rst", rand_vec(0), rand_vec(1));

        // start held high: accepts every N+2 cycles, each with operands present at its accept edge.
        for (int c = 0; c < 26; c++) begin
            start  = (c < 20);
            w_flat = rand_vec(c % 3);
            a_flat = rand_vec(1);
            if (start && (c % (N + 2) == 0)) expq.push_back(model(w_flat, a_flat));
            tick();
            chk($sformatf("b2b_done%0d", c), 32'(done), 32'(c % (N + 2) == N + 1 && c < 24));
            if (done) begin
                if (expq.size() == 0) chk("b2b_underflow", 32'd1, 32'd0);
                else chk($sformatf("b2b_out%0d", c), 32'(out), 32'(expq.pop_front()));
            end
        end
        chk("b2b_left", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
